// File: rtl/ga_pkg.sv
// Shared definitions for the GA run sequencer: state encoding, default widths
// and the mapping from a state to the pipeline stage it drives.
package ga_pkg;

    localparam int POP_W_DEFAULT = 7501;
    localparam int GEN_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SELECT = 3'd2,
        CROSS  = 3'd3,
        MUTATE = 3'd4,
        FINISH = 3'd5
    } ga_state_e;

    // One bit per launchable stage, indexed by the STG_* constants.
    typedef logic [3:0] stage_vec_t;

    localparam int STG_INIT = 0;
    localparam int STG_SEL  = 1;
    localparam int STG_XO   = 2;
    localparam int STG_MUT  = 3;

    function automatic stage_vec_t stage_of(input ga_state_e st);
        stage_vec_t v;
        v = '0;
        case (st)
            INIT:    v[STG_INIT] = 1'b1;
            SELECT:  v[STG_SEL]  = 1'b1;
            CROSS:   v[STG_XO]   = 1'b1;
            MUTATE:  v[STG_MUT]  = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ga_edge_det.sv
// Rising-edge detector for a stage completion level: a done held high for
// several cycles produces a single rise in the first of them.
module ga_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/ga_sequencer.sv
// Run controller for a genetic-algorithm pipeline: launches init, select,
// optional crossover and mutate stages per generation and owns the population.
module ga_sequencer
    import ga_pkg::*;
#(
    parameter int POP_W = POP_W_DEFAULT,
    parameter int GEN_W = GEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [GEN_W-1:0] max_gen,
    input  logic             xover_en,
    input  logic [POP_W-1:0] in_pop,
    input  logic [POP_W-1:0] mut_pop,
    input  logic             in_done,
    input  logic             sel_done,
    input  logic             xo_done,
    input  logic             mut_done,
    output logic             in_start,
    output logic             sel_start,
    output logic             xo_start,
    output logic             mut_start,
    output logic [POP_W-1:0] population,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             run_done
);

    ga_state_e        state;
    ga_state_e        state_next;
    logic [GEN_W-1:0] max_gen_q;
    logic             xover_q;
    logic             in_rise;
    logic             sel_rise;
    logic             xo_rise;
    logic             mut_rise;
    logic [GEN_W-1:0] gen_next;
    logic             take_start;
    logic             load_init;
    logic             load_mut;
    stage_vec_t       launch;

    ga_edge_det u_in_edge (
        .clk   (clk),
        .rst   (rst),
        .level (in_done),
        .rise  (in_rise)
    );

    ga_edge_det u_sel_edge (
        .clk   (clk),
        .rst   (rst),
        .level (sel_done),
        .rise  (sel_rise)
    );

    ga_edge_det u_xo_edge (
        .clk   (clk),
        .rst   (rst),
        .level (xo_done),
        .rise  (xo_rise)
    );

    ga_edge_det u_mut_edge (
        .clk   (clk),
        .rst   (rst),
        .level (mut_done),
        .rise  (mut_rise)
    );

    // Saturating increment; an all-ones limit still matches before any wrap.
    assign gen_next   = (gen_count == {GEN_W{1'b1}}) ? gen_count : gen_count + GEN_W'(1);
    assign take_start = (state == IDLE) && start;

    always_comb begin
        state_next = state;
        load_init  = 1'b0;
        load_mut   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (in_rise) begin
                    load_init = 1'b1;
                    if (max_gen_q == '0) begin
                        state_next = FINISH;
                    end else begin
                        state_next = SELECT;
                    end
                end
            end
            SELECT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (sel_rise) begin
                    if (xover_q) begin
                        state_next = CROSS;
                    end else begin
                        state_next = MUTATE;
                    end
                end
            end
            CROSS: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (xo_rise) begin
                    state_next = MUTATE;
                end
            end
            MUTATE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (mut_rise) begin
                    load_mut = 1'b1;
                    if (gen_next == max_gen_q) begin
                        state_next = FINISH;
                    end else begin
                        state_next = SELECT;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Launch pulses are registered so each lands in the first cycle of its stage.
    assign launch = stage_of(state_next) & ~stage_of(state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_start  <= 1'b0;
            sel_start <= 1'b0;
            xo_start  <= 1'b0;
            mut_start <= 1'b0;
        end else begin
            state     <= state_next;
            in_start  <= launch[STG_INIT];
            sel_start <= launch[STG_SEL];
            xo_start  <= launch[STG_XO];
            mut_start <= launch[STG_MUT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            population <= '0;
            gen_count  <= '0;
            max_gen_q  <= '0;
            xover_q    <= 1'b0;
        end else begin
            if (take_start) begin
                max_gen_q <= max_gen;
                xover_q   <= xover_en;
                gen_count <= '0;
            end
            if (load_init) begin
                population <= in_pop;
            end
            if (load_mut) begin
                population <= mut_pop;
                gen_count  <= gen_next;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign run_done = (state == FINISH);

endmodule

// File: tb/tb_ga_sequencer.sv
// Randomized bench for ga_sequencer: automatic stage responders plus a
// run-level model of the expected launch/finish event order and final values.
module tb_ga_sequencer;

    localparam int PW = 40;
    localparam int GW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [GW-1:0] max_gen;
    logic          xover_en;
    logic [PW-1:0] in_pop;
    logic [PW-1:0] mut_pop;
    logic          in_done;
    logic          sel_done;
    logic          xo_done;
    logic          mut_done;
    logic          in_start;
    logic          sel_start;
    logic          xo_start;
    logic          mut_start;
    logic [PW-1:0] population;
    logic [GW-1:0] gen_count;
    logic          busy;
    logic          run_done;

    int compared   = 0;
    int mismatched = 0;
    int run_id     = 0;

    // Event codes: 1 in_start, 2 sel_start, 3 xo_start, 4 mut_start, 5 run_done.
    int obs[$];
    int exp_seq[$];

    logic [3:0]    auto_mask = 4'b1111;
    logic [3:0]    auto_done = 4'b0000;
    logic [3:0]    pulses;
    logic          sel_man   = 1'b0;
    logic          mut_man   = 1'b0;
    int            hold_cycles = 0;
    int            req[4]    = '{default: 0};
    int            srv[4]    = '{default: 0};
    int            gap_c[4]  = '{default: 0};
    int            hold_c[4] = '{default: 0};
    logic [3:0]    active    = 4'b0000;
    logic [PW-1:0] last_in   = '0;
    logic [PW-1:0] last_mut  = '0;

    assign in_done  = auto_done[0];
    assign sel_done = auto_done[1] | sel_man;
    assign xo_done  = auto_done[2];
    assign mut_done = auto_done[3] | mut_man;

    ga_sequencer #(
        .POP_W (PW),
        .GEN_W (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .max_gen    (max_gen),
        .xover_en   (xover_en),
        .in_pop     (in_pop),
        .mut_pop    (mut_pop),
        .in_done    (in_done),
        .sel_done   (sel_done),
        .xo_done    (xo_done),
        .mut_done   (mut_done),
        .in_start   (in_start),
        .sel_start  (sel_start),
        .xo_start   (xo_start),
        .mut_start  (mut_start),
        .population (population),
        .gen_count  (gen_count),
        .busy       (busy),
        .run_done   (run_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Population sources only change while their done level is low.
    initial begin
        in_pop  = '0;
        mut_pop = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!in_done)  in_pop  = PW'({$urandom, $urandom});
            if (!mut_done) mut_pop = PW'({$urandom, $urandom});
        end
    end

    // Monitor and stage responders: each launch is answered after a random gap
    // with a done level held for hold_cycles (random when zero).
    initial begin
        forever begin
            @(negedge clk);
            pulses = {mut_start, xo_start, sel_start, in_start};
            for (int s = 0; s < 4; s++) begin
                if (pulses[s]) begin
                    obs.push_back(s + 1);
                    if (auto_mask[s]) req[s]++;
                end
                if (!active[s] && req[s] > srv[s] && !auto_done[s]) begin
                    srv[s]++;
                    active[s] = 1'b1;
                    gap_c[s]  = $urandom_range(0, 3);
                end
                if (active[s]) begin
                    if (gap_c[s] > 0) begin
                        gap_c[s]--;
                    end else if (!auto_done[s]) begin
                        auto_done[s] = 1'b1;
                        hold_c[s] = (hold_cycles > 0) ? hold_cycles : $urandom_range(1, 10);
                        if (s == 0) last_in  = in_pop;
                        if (s == 3) last_mut = mut_pop;
                    end else begin
                        hold_c[s]--;
                        if (hold_c[s] == 0) begin
                            auto_done[s] = 1'b0;
                            active[s]    = 1'b0;
                        end
                    end
                end
            end
            if (run_done) obs.push_back(5);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return in_start;
            1:       return sel_start;
            2:       return xo_start;
            3:       return mut_start;
            default: return (gen_count == GW'(1));
        endcase
    endfunction

    task automatic waitFor(input string tag, input int which, input int budget);
        int n = 0;
        while (!probe(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(probe(which)), 64'd1);
    endtask

    task automatic buildExpected(input int mg, input bit xo);
        exp_seq.delete();
        exp_seq.push_back(1);
        for (int r = 0; r < mg; r++) begin
            exp_seq.push_back(2);
            if (xo) exp_seq.push_back(3);
            exp_seq.push_back(4);
        end
        exp_seq.push_back(5);
    endtask

    task automatic compareSeq(input int base, input string tag);
        checkOutput({tag, "_len"}, 64'(obs.size() - base), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (base + i < obs.size())
                checkOutput($sformatf("%s_ev%0d", tag, i), 64'(obs[base + i]), 64'(exp_seq[i]));
        end
    endtask

    task automatic launchRun(input int mg, input bit xo);
        max_gen  = GW'(mg);
        xover_en = xo;
        start    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start    = 1'b0;
        max_gen  = GW'($urandom);
        xover_en = 1'($urandom_range(0, 1));
    endtask

    task automatic awaitIdle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_population"}, 64'(population), 64'd0);
        checkOutput({tag, "_gen_count"},  64'(gen_count),  64'd0);
        checkOutput({tag, "_in_start"},   64'(in_start),   64'd0);
        checkOutput({tag, "_sel_start"},  64'(sel_start),  64'd0);
        checkOutput({tag, "_xo_start"},   64'(xo_start),   64'd0);
        checkOutput({tag, "_mut_start"},  64'(mut_start),  64'd0);
        checkOutput({tag, "_busy"},       64'(busy),       64'd0);
        checkOutput({tag, "_run_done"},   64'(run_done),   64'd0);
    endtask

    task automatic applyStimulus(input int mg, input bit xo, input int hold);
        int    base;
        string tg;
        run_id++;
        tg = $sformatf("run%0d_g%0d_x%0d", run_id, mg, xo);
        hold_cycles = hold;
        base = obs.size();
        launchRun(mg, xo);
        awaitIdle(tg, 3000);
        buildExpected(mg, xo);
        compareSeq(base, tg);
        checkOutput({tg, "_gen_count"}, 64'(gen_count), 64'(mg));
        checkOutput({tg, "_population"}, 64'(population), (mg == 0) ? 64'(last_in) : 64'(last_mut));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst      = 1'b1;
        start    = 1'b1;
        abort    = 1'b0;
        max_gen  = '0;
        xover_en = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("por");
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("por_idle_busy", 64'(busy), 64'd0);

        applyStimulus(3, 1'b0, 10);
        applyStimulus(2, 1'b1, 0);
        applyStimulus(0, 1'b0, 0);

        // Simultaneous sel/mut edges while selecting: only the select edge counts.
        $display("[TB] directed: simultaneous done edges in SELECT");
        hold_cycles = 1;
        auto_mask   = 4'b1101;
        base = obs.size();
        launchRun(1, 1'b1);
        waitFor("simul_wait_sel", 1, 200);
        sel_man = 1'b1;
        mut_man = 1'b1;
        @(negedge clk);
        sel_man = 1'b0;
        mut_man = 1'b0;
        checkOutput("simul_xo_start",   64'(xo_start),   64'd1);
        checkOutput("simul_gen_count",  64'(gen_count),  64'd0);
        checkOutput("simul_population", 64'(population), 64'(last_in));
        auto_mask = 4'b1111;
        awaitIdle("simul", 1000);
        buildExpected(1, 1'b1);
        compareSeq(base, "simul");
        checkOutput("simul_final_gen", 64'(gen_count), 64'd1);
        repeat (15) @(negedge clk);

        // Abort coinciding with a mutate edge in the second generation.
        $display("[TB] directed: abort with mut_done edge");
        base = obs.size();
        launchRun(3, 1'b0);
        waitFor("abort_wait_gen1", 4, 500);
        auto_mask = 4'b0111;
        waitFor("abort_wait_mut", 3, 500);
        abort   = 1'b1;
        mut_man = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        mut_man = 1'b0;
        checkOutput("abort_busy",       64'(busy),       64'd0);
        checkOutput("abort_gen_count",  64'(gen_count),  64'd1);
        checkOutput("abort_population", 64'(population), 64'(last_mut));
        repeat (15) @(negedge clk);
        exp_seq = '{1, 2, 4, 2, 4};
        compareSeq(base, "abort");
        auto_mask = 4'b1111;

        // Reset during crossover of the second generation, with start also high.
        $display("[TB] directed: reset mid-CROSS");
        launchRun(2, 1'b1);
        waitFor("rst_wait_gen1", 4, 500);
        auto_mask = 4'b1011;
        waitFor("rst_wait_xo", 2, 500);
        repeat (2) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkResetOutputs("midrst");
        rst   = 1'b0;
        start = 1'b0;
        auto_mask = 4'b1111;
        repeat (15) @(negedge clk);
        applyStimulus(2, 1'b1, 0);

        for (int k = 0; k < 6; k++) begin
            applyStimulus($urandom_range(0, 5), 1'($urandom_range(0, 1)), 0);
        end

        // All-ones limit terminates on equality rather than wrapping.
        applyStimulus(15, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ga_sequencer.md
GA_SEQUENCER -- requirements
Module: ga_sequencer

Interface
REQ-001 SHALL have parameter POP_W, default 7501, width of the population vector.
REQ-002 SHALL have parameter GEN_W, default 16, width of the generation counter and limit.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begins a run when high in IDLE.
REQ-006 SHALL have port abort  input  1  returns to IDLE from any non-IDLE state.
REQ-007 SHALL have port max_gen  input  GEN_W  number of generations; sampled on the start cycle.
REQ-008 SHALL have port xover_en  input  1  enables the crossover stage; sampled on the start cycle.
REQ-009 SHALL have port in_pop  input  POP_W  initial population from the init stage.
REQ-010 SHALL have port mut_pop  input  POP_W  mutated population from the mutate stage.
REQ-011 SHALL have ports in_done, sel_done, xo_done, mut_done  input  1 each  stage completion levels.
REQ-012 SHALL have ports in_start, sel_start, xo_start, mut_start  output  1 each  single-cycle stage launch pulses.
REQ-013 SHALL have port population  output  POP_W  current population register.
REQ-014 SHALL have port gen_count  output  GEN_W  completed generations.
REQ-015 SHALL have ports busy  output  1  high when not IDLE, and run_done  output  1  single-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, INIT, SELECT, CROSS, MUTATE, FINISH.
REQ-017 SHALL treat each *_done input as a rising-edge event (registered previous value), so a done held high for N cycles counts once.
REQ-018 SHALL move IDLE->INIT when start=1, latching max_gen/xover_en, clearing gen_count and pulsing in_start one cycle after the transition.
REQ-019 SHALL pulse the matching *_start exactly once, in the first cycle of each entry into INIT, SELECT, CROSS or MUTATE.
REQ-020 SHALL in INIT, on in_done edge, load population<=in_pop and go to FINISH if latched max_gen==0, else SELECT.
REQ-021 SHALL in SELECT, on sel_done edge, go to CROSS if xover_en latched, else MUTATE.
REQ-022 SHALL in CROSS, on xo_done edge, go to MUTATE.
REQ-023 SHALL in MUTATE, on mut_done edge, load population<=mut_pop, increment gen_count, and go to FINISH if the new count equals max_gen, else SELECT.
REQ-024 SHALL ignore done edges from stages other than the current one, including simultaneous ones.
REQ-025 SHALL in FINISH pulse run_done one cycle and return to IDLE the next cycle; population and gen_count hold.
REQ-026 SHALL give abort priority over any done edge in the same cycle; abort returns to IDLE without run_done, population held.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL saturate gen_count at all-ones rather than wrap (max_gen all-ones terminates on equality first).

Reset
REQ-029 SHALL on rst=1 enter IDLE and clear population, gen_count, all *_start, busy, run_done and done-edge history to 0.
REQ-030 SHALL give rst priority over start, abort and done inputs; reset mid-run discards the run.

Structure
REQ-031 SHALL take the state encoding and POP_W/GEN_W defaults from shared package ga_pkg.
REQ-032 SHALL instantiate sub-module ga_edge_det (one per done input) for rising-edge detection.

Verification
REQ-033 SHALL cover: max_gen=3, xover_en=0, each done held 10 cycles -> 3 SELECT/MUTATE rounds, gen_count=3, one run_done, population=mut_pop.
REQ-034 SHALL cover: max_gen=2, xover_en=1 -> sel_start, xo_start, mut_start each pulse twice in order, run_done once.
REQ-035 SHALL cover: max_gen=0 -> in_start once, population=in_pop after in_done, run_done with no sel_start.
REQ-036 SHALL cover: in SELECT, mut_done and sel_done rise together -> only the SELECT transition, gen_count unchanged.
REQ-037 SHALL cover: abort asserted with mut_done edge in MUTATE -> IDLE, gen_count unchanged, no run_done.
REQ-038 SHALL cover: rst mid-CROSS -> all outputs 0 next cycle; a new start runs normally.
